// File: rtl/pipe_pkg.sv
// Shared constants for the RV32I pipeline segment registers.
package pipe_pkg;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Default datapath width
    localparam int unsigned XLEN = 32;

    // Default stall counter width
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_seg_reg_seg_skid_slot.sv
// One payload slot: data register plus valid bit with load/clear controls.
// A load writes both data and valid (valid may be loaded as 0 for bubble
// injection); clear drops only the valid bit so the data is retained.
module seg_skid_slot #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    input  logic             clear,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Slot state: load has priority over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (load) begin
            valid <= load_valid;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_seg_reg.sv
// Pipeline segment register with valid/ready flow control, hazard hold,
// flush with NOP bubble injection, optional skid slot and stall counter.
module pipe_seg_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(RV_NOP),
    parameter bit               SKID       = 1'b1,
    parameter int unsigned      CNT_W      = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             hold,
    input  logic             flush,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             dr;
    logic             out_xfer;
    logic             in_xfer;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_load;
    logic [WIDTH-1:0] main_load_data;
    logic             main_load_valid;
    logic             main_clear;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic [CNT_W-1:0] stall_cnt_q;

    assign dr       = out_ready & ~hold;
    assign out_xfer = main_valid & dr;
    assign in_xfer  = in_valid & in_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign stall_cnt = stall_cnt_q;

    // Main slot control: flush, skid refill, direct load, drain (in priority order)
    always_comb begin
        main_load       = 1'b0;
        main_load_data  = in_data;
        main_load_valid = 1'b1;
        main_clear      = 1'b0;
        if (flush) begin
            main_load       = 1'b1;
            main_load_data  = BUBBLE_VAL;
            main_load_valid = 1'b0;
        end else if (skid_valid && out_xfer) begin
            main_load      = 1'b1;
            main_load_data = skid_data;
        end else if (in_xfer && (!main_valid || out_xfer)) begin
            main_load = 1'b1;
        end else if (out_xfer) begin
            main_clear = 1'b1;
        end
    end

    seg_skid_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .load_data  (main_load_data),
        .load_valid (main_load_valid),
        .clear      (main_clear),
        .valid      (main_valid),
        .data       (main_data)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // in_ready comes only from registered state plus hold/flush
            assign in_ready = ~hold & ~flush & ~skid_valid;

            // Skid captures an accepted item when main is full and not draining
            always_comb begin
                skid_load  = ~flush & in_xfer & main_valid & ~out_xfer;
                skid_clear = flush | (skid_valid & out_xfer);
            end

            seg_skid_slot #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_skid (
                .clk        (clk),
                .rst        (rst),
                .load       (skid_load),
                .load_data  (in_data),
                .load_valid (1'b1),
                .clear      (skid_clear),
                .valid      (skid_valid),
                .data       (skid_data)
            );
        end else begin : g_noskid
            assign in_ready   = ~hold & ~flush & (~main_valid | out_ready);
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
        end
    endgenerate

    // Saturating count of cycles where a valid payload was not taken downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_clr) begin
            stall_cnt_q <= '0;
        end else if (main_valid && !dr && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Self-checking bench: one SKID=1 (CNT_W=4) and one SKID=0 instance driven
// with the same stimulus, each compared against a small FIFO-level model.
module tb_pipe_seg_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        hold;
    logic        flush;
    logic        stall_clr;

    logic [1:0]  in_ready_v;
    logic [1:0]  out_valid_v;
    logic [31:0] out_data_v [2];
    logic [3:0]  cnt1;
    logic [15:0] cnt0;

    // index 1: SKID=1, index 0: SKID=0
    logic [31:0] m_buf [2][2];
    int          m_n   [2];
    logic [31:0] m_od  [2];
    int          m_sc  [2];
    int          m_max [2];
    logic        m_ir  [2];
    logic        acc1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_seg_reg #(
        .WIDTH (32),
        .SKID  (1'b1),
        .CNT_W (4)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[1]),
        .in_data   (in_data),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready),
        .out_data  (out_data_v[1]),
        .hold      (hold),
        .flush     (flush),
        .stall_clr (stall_clr),
        .stall_cnt (cnt1)
    );

    pipe_seg_reg #(
        .WIDTH (32),
        .SKID  (1'b0),
        .CNT_W (16)
    ) u_noskid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[0]),
        .in_data   (in_data),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready),
        .out_data  (out_data_v[0]),
        .hold      (hold),
        .flush     (flush),
        .stall_clr (stall_clr),
        .stall_cnt (cnt0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return (i == 1) ? {28'b0, cnt1} : {16'b0, cnt0};
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s.valid[%0d]", tag, i), {31'b0, out_valid_v[i]},
                     (m_n[i] > 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s.data[%0d]", tag, i), out_data_v[i], m_od[i]);
            check_eq($sformatf("%s.cnt[%0d]", tag, i), cnt_of(i), 32'(m_sc[i]));
        end
    endtask

    // Asserted between edges; contents must vanish without waiting for a clock
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_n[i]  = 0;
            m_od[i] = '0;
            m_sc[i] = 0;
        end
        check_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("reset.in_ready[%0d]", i), {31'b0, in_ready_v[i]}, 32'd1);
    endtask

    // One clock of stimulus, starting and ending at a falling edge
    task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                        input logic h, input logic fl, input logic clr);
        logic dr;
        logic stalled;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        hold      = h;
        flush     = fl;
        stall_clr = clr;
        #1;
        for (int i = 0; i < 2; i++) begin
            // SKID=1 accepts while it has room for two; SKID=0 needs an empty or draining slot
            m_ir[i] = !h && !fl && ((i == 1) ? (m_n[i] < 2) : (m_n[i] == 0 || ordy));
            check_eq($sformatf("in_ready[%0d]", i), {31'b0, in_ready_v[i]}, {31'b0, m_ir[i]});
        end
        acc1 = iv && m_ir[1];
        @(posedge clk);
        dr = ordy && !h;
        for (int i = 0; i < 2; i++) begin
            stalled = (m_n[i] > 0) && !dr;
            if (fl) begin
                m_n[i]  = 0;
                m_od[i] = 32'(RV_NOP);
            end else begin
                if (m_n[i] > 0 && dr) begin
                    m_buf[i][0] = m_buf[i][1];
                    m_n[i]--;
                end
                if (iv && m_ir[i]) begin
                    m_buf[i][m_n[i]] = id;
                    m_n[i]++;
                end
                if (m_n[i] > 0) m_od[i] = m_buf[i][0];
            end
            if (clr) m_sc[i] = 0;
            else if (stalled && m_sc[i] < m_max[i]) m_sc[i]++;
        end
        @(negedge clk);
        check_outputs("step");
    endtask

    initial begin
        logic [8:0] bp_pat;
        int         k;
        m_max[0] = 65535;
        m_max[1] = 15;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        @(negedge clk);

        // Reset and pass-through
        do_reset();
        check_eq("pt.reset_data", out_data_v[1], 32'h0);
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pt.first", out_data_v[1], 32'h100);
        step(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pt.third", out_data_v[1], 32'h108);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pt.cnt", {28'b0, cnt1}, 32'd0);

        // Backpressure: downstream stalls for 3 cycles after the first output
        do_reset();
        bp_pat = 9'b1_1111_0001;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            step(k < 4, 32'hA0 + 32'(k), bp_pat[c], 1'b0, 1'b0, 1'b0);
            if (acc1) k++;
        end
        check_eq("bp.accepted", 32'(k), 32'd4);
        check_eq("bp.cnt", {28'b0, cnt1}, 32'd3);

        // Flush with main and skid both full
        do_reset();
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("flush.valid", {31'b0, out_valid_v[1]}, 32'd0);
        check_eq("flush.data", out_data_v[1], 32'h13);
        step(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("flush.refill", out_data_v[1], 32'h208);

        // Hold freezes everything while counting as stalled
        do_reset();
        step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("hold.data", out_data_v[1], 32'h300);
        check_eq("hold.cnt", {28'b0, cnt1}, 32'd2);

        // Counter saturation and clear-over-increment
        do_reset();
        step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sat.cnt", {28'b0, cnt1}, 32'd15);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("sat.clr", {28'b0, cnt1}, 32'd0);

        // Randomized traffic with occasional mid-stream reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(9) < 7, $urandom, $urandom_range(9) < 6,
                     $urandom_range(9) == 0, $urandom_range(19) == 0,
                     $urandom_range(29) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_seg_reg.md
# pipe_seg_reg

Parametrised pipeline segment register for the RV32I core. It replaces the fixed 32-bit enable-only stage registers between IF/ID/EX/MEM/WB and adds valid/ready flow control, hazard hold, synchronous flush with NOP bubble injection, an optional one-entry skid buffer for full throughput under backpressure, and a saturating stall counter for performance analysis.

## Interface
- WIDTH, 32, payload width in bits.
- RESET_VAL, 0, `out_data` value after reset.
- BUBBLE_VAL, 32'h0000_0013, `out_data` value after flush (RV32I NOP `addi x0,x0,0`, zero-extended or truncated to WIDTH).
- SKID, 1, 1 = one-entry skid buffer with registered `in_ready`; 0 = no skid, combinational `in_ready`.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds valid payload.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to next stage.
- hold  in  1  hazard-unit stall: freezes all transfers.
- flush  in  1  synchronous kill of stage contents.
- stall_clr  in  1  synchronous clear of `stall_cnt`.
- stall_cnt  out  CNT_W  saturating count of backpressured cycles.

## Operation
- Effective downstream ready: `dr = out_ready & ~hold`.
- Output transfer: `out_valid & dr`.
- Input transfer: `in_valid & in_ready`.
- `in_ready`:
  - SKID=1: `~hold & ~flush & ~skid_valid`.
  - SKID=0: `~hold & ~flush & (~out_valid | out_ready)`.
- Main slot, SKID=1, priority order:
  - flush, which empties both slots;
  - skid full and output transfer: skid moves to main, skid empties;
  - input transfer and (main empty or output transfer): input goes to main;
  - input transfer and main full without output transfer: input goes to skid;
  - output transfer with no refill: main empties.
- SKID=0: the main slot alone follows the same rules. The skid slot is absent.
- Ordering: strict FIFO, with no loss or duplication.
- On flush: next cycle `out_valid=0`, skid empty, `out_data=BUBBLE_VAL`. Flush overrides hold and input transfer, and `in_ready` is forced to 0 in the flush cycle, so no upstream item is consumed and then dropped.
- When `out_valid=0` and not flushed, `out_data` holds its last value.
- hold=1: no input or output transfer; all slots and `out_data` frozen. hold and flush together: flush wins.
- stall_cnt:
  - increments when `out_valid & ~dr`;
  - saturates at 2^CNT_W−1;
  - stall_clr sets it to 0, which has priority over increment;
  - flush does not clear it.

## Timing
- Reset values: `out_valid=0`, `out_data=RESET_VAL`, skid empty, `stall_cnt=0`. `in_ready` after reset is 1 when hold=0 and flush=0.
- Latency: input accepted at edge N appears on `out_data` after edge N (one cycle).
- Throughput: one item per cycle when `dr=1`, for both SKID values.
- SKID=1: `in_ready` depends only on registers plus hold/flush. There is no `out_ready` to `in_ready` combinational path.
- Reset asserted mid-stream: all contents discarded immediately. No transfer completes until the first edge after reset deasserts.

## Structure
- Shared package `pipe_pkg`:
  - constant `RV_NOP = 32'h0000_0013`;
  - default `XLEN = 32`;
  - default stall counter width.
- Sub-module `seg_skid_slot`: one WIDTH-wide data register plus valid bit, with load/clear controls and reset value. It is instantiated for the main slot, and also for the skid slot under `generate` when SKID=1.

## Test plan
- Reset and pass-through: rst pulse, then in_valid=1 with data 0x100, 0x104, 0x108, out_ready=1 → after reset `out_data=0`, `out_valid=0`; outputs appear one cycle later in order; `stall_cnt` stays 0.
- Backpressure with SKID=1: stream 0xA0..0xA3, drop out_ready for 3 cycles after the first output → one item captured in skid, `in_ready=0` while skid full, all four items delivered in order, `stall_cnt=3`.
- Flush: stage full with 0x200 and skid full with 0x204, assert flush with in_valid=1 → `in_ready=0` that cycle; next cycle `out_valid=0`, `out_data=0x13`; the upstream item is still presented and accepted the following cycle.
- Hold: stage holds 0x300, hold=1 for 2 cycles with out_ready=1 → `out_data` stays 0x300, no transfer, `in_ready=0`; `stall_cnt` increments by 2.
- Counter saturation and clear: CNT_W=4, out_ready=0 for 20 cycles with stage valid → `stall_cnt` sticks at 15; stall_clr and increment in the same cycle → `stall_cnt=0`.
- SKID=0 variant: same stream as the backpressure test → same output order; `in_ready` follows `out_ready` in the same cycle when the stage is full.
